cv32e40s_div_ctrl: RTL and testbench

- EX-stage initiator for the serial divider valid/ready handshake. It is the issuing side of the divider interface.
- Accepts a DIV/DIVU/REM/REMU request from ID and latches the operator and operands.
- Drives the divider and holds its inputs stable for the whole operation.
- Captures the divider result into an output register, presents it to WB with backpressure, and supports kill at any time.

---
 rtl/cv32e40s_div_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cv32e40s_div_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_div_ctrl.sv
// cv32e40s_div_ctrl: EX-stage issuer for the serial divider valid/ready handshake.
// Optional last-result cache is built in when CV32E40S_DIV_RESULT_CACHE_EN is defined.

package cv32e40s_div_pkg;
  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_opcode_e;
endpackage

module cv32e40s_div_ctrl
  import cv32e40s_div_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  div_opcode_e      id_operator_i,
  input  logic [31:0]      id_op_a_i,
  input  logic [31:0]      id_op_b_i,
  input  logic             id_dit_i,
  input  logic             kill_i,

  output logic             div_en_o,
  output logic             div_valid_o,
  output logic             div_ready_o,
  output div_opcode_e      div_operator_o,
  output logic [31:0]      div_op_a_o,
  output logic [31:0]      div_op_b_o,
  output logic             div_dit_o,
  input  logic             div_valid_i,
  input  logic             div_ready_i,
  input  logic [31:0]      div_result_i,

  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,

  output logic             busy_o,
  output logic [CNT_W-1:0] div_cycles_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } state_e;

  state_e           state_q, state_d;
  div_opcode_e      operator_q;
  logic [31:0]      op_a_q, op_b_q, result_q;
  logic             dit_q;
  logic [CNT_W-1:0] cycles_q;

  logic             accept;
  logic             complete;
  logic             cache_hit;
  logic [31:0]      cached_result;

  // The divider always returns to idle before a new request is issued (BUSY is only
  // left via its result, kill or reset), so its ready acknowledge carries no extra information.
  logic unused_div_ready;
  assign unused_div_ready = div_ready_i;

  assign accept   = id_valid_i && !kill_i &&
                    ((state_q == IDLE) || ((state_q == HOLD) && wb_ready_i));
  assign complete = (state_q == BUSY) && div_valid_i && !kill_i;

`ifdef CV32E40S_DIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  div_opcode_e cache_op_q;
  logic [31:0] cache_a_q, cache_b_q, cache_res_q;

  assign cache_hit     = cache_valid_q && !id_dit_i &&
                         (id_operator_i == cache_op_q) &&
                         (id_op_a_i == cache_a_q) && (id_op_b_i == cache_b_q);
  assign cached_result = cache_res_q;

  always_ff @(posedge clk) begin
    if (rst || kill_i) begin
      cache_valid_q <= 1'b0;
    end else if (complete) begin
      cache_valid_q <= 1'b1;
    end
  end

  // NOTE: the cache payload has no reset; cache_valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    if (complete) begin
      cache_op_q  <= operator_q;
      cache_a_q   <= op_a_q;
      cache_b_q   <= op_b_q;
      cache_res_q <= div_result_i;
    end
  end
`else
  assign cache_hit     = 1'b0;
  assign cached_result = '0;
`endif

  always_comb begin
    // NOTE: every output is given a default first, so no path through the case infers a latch.
    state_d     = state_q;
    id_ready_o  = 1'b0;
    div_en_o    = 1'b0;
    div_valid_o = 1'b0;
    div_ready_o = 1'b0;
    wb_valid_o  = 1'b0;

    case (state_q)
      IDLE: begin
        id_ready_o = 1'b1;
      end
      BUSY: begin
        div_en_o    = 1'b1;
        div_valid_o = 1'b1;
        div_ready_o = 1'b1;
        if (div_valid_i) state_d = HOLD;
      end
      HOLD: begin
        wb_valid_o = 1'b1;
        id_ready_o = wb_ready_i;
        if (wb_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) state_d = cache_hit ? HOLD : BUSY;

    // Kill overrides everything; dropping div_valid_o aborts the divider.
    if (kill_i) begin
      state_d     = IDLE;
      div_valid_o = 1'b0;
      wb_valid_o  = 1'b0;
      id_ready_o  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      operator_q <= DIV_DIV;
      op_a_q     <= '0;
      op_b_q     <= '0;
      dit_q      <= 1'b0;
      result_q   <= '0;
      cycles_q   <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        operator_q <= id_operator_i;
        op_a_q     <= id_op_a_i;
        op_b_q     <= id_op_b_i;
        dit_q      <= id_dit_i;
        cycles_q   <= '0;
      end else if ((state_q == BUSY) && (cycles_q != '1)) begin
        cycles_q <= cycles_q + CNT_W'(1);
      end

      if (complete) begin
        result_q <= div_result_i;
      end else if (accept && cache_hit) begin
        result_q <= cached_result;
      end
    end
  end

  assign div_operator_o = operator_q;
  assign div_op_a_o     = op_a_q;
  assign div_op_b_o     = op_b_q;
  assign div_dit_o      = dit_q;
  assign wb_result_o    = result_q;
  assign busy_o         = (state_q != IDLE);
  assign div_cycles_o   = cycles_q;

endmodule

// File: tb/tb_cv32e40s_div_ctrl.sv
// Directed self-checking bench for cv32e40s_div_ctrl; the bench plays the divider and WB.
// Cache-specific expectations follow CV32E40S_DIV_RESULT_CACHE_EN.

module tb_cv32e40s_div_ctrl;
  import cv32e40s_div_pkg::*;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid_i;
  logic             id_ready_o;
  div_opcode_e      id_operator_i;
  logic [31:0]      id_op_a_i;
  logic [31:0]      id_op_b_i;
  logic             id_dit_i;
  logic             kill_i;
  logic             div_en_o;
  logic             div_valid_o;
  logic             div_ready_o;
  div_opcode_e      div_operator_o;
  logic [31:0]      div_op_a_o;
  logic [31:0]      div_op_b_o;
  logic             div_dit_o;
  logic             div_valid_i;
  logic             div_ready_i;
  logic [31:0]      div_result_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [31:0]      wb_result_o;
  logic             busy_o;
  logic [CNT_W-1:0] div_cycles_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e40s_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready_o),
    .id_operator_i  (id_operator_i),
    .id_op_a_i      (id_op_a_i),
    .id_op_b_i      (id_op_b_i),
    .id_dit_i       (id_dit_i),
    .kill_i         (kill_i),
    .div_en_o       (div_en_o),
    .div_valid_o    (div_valid_o),
    .div_ready_o    (div_ready_o),
    .div_operator_o (div_operator_o),
    .div_op_a_o     (div_op_a_o),
    .div_op_b_o     (div_op_b_o),
    .div_dit_o      (div_dit_o),
    .div_valid_i    (div_valid_i),
    .div_ready_i    (div_ready_i),
    .div_result_i   (div_result_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_result_o    (wb_result_o),
    .busy_o         (busy_o),
    .div_cycles_o   (div_cycles_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic dit);
    id_valid_i    = 1'b1;
    id_operator_i = op;
    id_op_a_i     = a;
    id_op_b_i     = b;
    id_dit_i      = dit;
    #1 check("id_ready_at_issue", id_ready_o, 1);
    cyc();
    id_valid_i = 1'b0;
    #1;
  endtask

  // Divider model: result appears after wait_n further BUSY cycles, for one cycle.
  task automatic respond(input int wait_n, input logic [31:0] res);
    repeat (wait_n) cyc();
    div_valid_i  = 1'b1;
    div_result_i = res;
    #1 check("no_comb_wb_valid", wb_valid_o, 0);
    cyc();
    div_valid_i  = 1'b0;
    div_result_i = 32'hDEAD_BEEF;
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid_i = 1'b0; id_operator_i = DIV_DIV; id_op_a_i = '0; id_op_b_i = '0;
    id_dit_i = 1'b0; kill_i = 1'b0; div_valid_i = 1'b0; div_ready_i = 1'b1;
    div_result_i = '0; wb_ready_i = 1'b0;
    cyc(); cyc();
    #1;
    check("rst_busy",       busy_o,       0);
    check("rst_id_ready",   id_ready_o,   1);
    check("rst_div_valid",  div_valid_o,  0);
    check("rst_wb_valid",   wb_valid_o,   0);
    check("rst_cycles",     div_cycles_o, 0);
    check("rst_wb_result",  wb_result_o,  0);
    rst = 1'b0;
    cyc();

    // DIVU 100/7 -> 14
    wb_ready_i = 1'b1;
    issue(DIV_DIVU, 32'd100, 32'd7, 1'b0);
    check("t1_div_valid",  div_valid_o,    1);
    check("t1_div_en",     div_en_o,       1);
    check("t1_div_ready",  div_ready_o,    1);
    check("t1_id_ready",   id_ready_o,     0);
    check("t1_operator",   div_operator_o, DIV_DIVU);
    check("t1_op_a",       div_op_a_o,     32'd100);
    check("t1_op_b",       div_op_b_o,     32'd7);
    respond(2, 32'd14);
    check("t1_wb_valid",   wb_valid_o,     1);
    check("t1_wb_result",  wb_result_o,    32'd14);
    check("t1_hold_divv",  div_valid_o,    0);
    check("t1_cycles",     div_cycles_o,   3);
    cyc(); #1;
    check("t1_idle",       busy_o,         0);
    check("t1_wb_low",     wb_valid_o,     0);

    // REM -7 % 2 -> -1, operands stable while ID inputs wander
    issue(DIV_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      id_op_a_i = 32'h5555_0000 + i;
      id_operator_i = DIV_DIVU;
      #1;
      check("t2_op_a_stable", div_op_a_o,     32'hFFFF_FFF9);
      check("t2_op_b_stable", div_op_b_o,     32'd2);
      check("t2_op_stable",   div_operator_o, DIV_REM);
      cyc();
    end
    respond(0, 32'hFFFF_FFFF);
    check("t2_wb_result",  wb_result_o,    32'hFFFF_FFFF);
    cyc();

    // DIV 5/0 -> -1 held under WB backpressure
    wb_ready_i = 1'b0;
    issue(DIV_DIV, 32'd5, 32'd0, 1'b0);
    respond(1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      div_valid_i  = 1'b1;
      div_result_i = 32'h1234_0000 + i;
      #1;
      check("t3_wb_valid",   wb_valid_o,  1);
      check("t3_wb_stable",  wb_result_o, 32'hFFFF_FFFF);
      check("t3_id_ready",   id_ready_o,  0);
      cyc();
    end
    div_valid_i = 1'b0;
    wb_ready_i  = 1'b1;
    #1 check("t3_id_ready_release", id_ready_o, 1);
    cyc(); #1;
    check("t3_idle",       busy_o,      0);

    // Kill on the third BUSY cycle, with a result arriving in the same cycle
    issue(DIV_DIVU, 32'd50, 32'd5, 1'b0);
    cyc(); cyc();
    kill_i       = 1'b1;
    div_valid_i  = 1'b1;
    div_result_i = 32'h0000_0077;
    #1;
    check("t4_kill_divv",  div_valid_o, 0);
    check("t4_kill_wbv",   wb_valid_o,  0);
    check("t4_kill_idr",   id_ready_o,  0);
    cyc();
    kill_i      = 1'b0;
    div_valid_i = 1'b0;
    #1;
    check("t4_idle",       busy_o,       0);
    check("t4_no_wb",      wb_valid_o,   0);
    check("t4_cycles",     div_cycles_o, 3);
    check("t4_discarded",  wb_result_o,  32'hFFFF_FFFF);
    issue(DIV_DIVU, 32'd9, 32'd3, 1'b0);
    respond(0, 32'd3);
    check("t4_wb_valid",   wb_valid_o,  1);
    check("t4_result",     wb_result_o, 32'd3);
    cyc();

    // Back-to-back DIVU 20/4 then REMU 20/3
    issue(DIV_DIVU, 32'd20, 32'd4, 1'b0);
    respond(1, 32'd5);
    id_valid_i    = 1'b1;
    id_operator_i = DIV_REMU;
    id_op_a_i     = 32'd20;
    id_op_b_i     = 32'd3;
    #1;
    check("t5_wb_valid",   wb_valid_o,  1);
    check("t5_result1",    wb_result_o, 32'd5);
    check("t5_id_ready",   id_ready_o,  1);
    cyc();
    id_valid_i = 1'b0;
    #1;
    check("t5_b2b_busy",   busy_o,         1);
    check("t5_b2b_divv",   div_valid_o,    1);
    check("t5_b2b_op",     div_operator_o, DIV_REMU);
    check("t5_b2b_op_b",   div_op_b_o,     32'd3);
    check("t5_b2b_cycles", div_cycles_o,   0);
    respond(0, 32'd2);
    check("t5_result2",    wb_result_o, 32'd2);
    cyc(); #1;
    check("t5_idle",       busy_o,      0);

    // Kill beats a request in IDLE
    id_valid_i = 1'b1;
    kill_i     = 1'b1;
    #1 check("t6_kill_idr", id_ready_o, 0);
    cyc();
    id_valid_i = 1'b0;
    kill_i     = 1'b0;
    #1;
    check("t6_idle",       busy_o,      0);
    check("t6_divv",       div_valid_o, 0);

    // Repeat DIVU 100/7: cache hit when enabled, BUSY otherwise; dit=1 always through BUSY
    issue(DIV_DIVU, 32'd100, 32'd7, 1'b0);
    respond(2, 32'd14);
    check("t7_first",      wb_result_o, 32'd14);
    cyc();
    issue(DIV_DIVU, 32'd100, 32'd7, 1'b0);
`ifdef CV32E40S_DIV_RESULT_CACHE_EN
    check("t7_hit_divv",   div_valid_o,  0);
    check("t7_hit_wbv",    wb_valid_o,   1);
    check("t7_hit_result", wb_result_o,  32'd14);
    check("t7_hit_cycles", div_cycles_o, 0);
    cyc();
`else
    check("t7_nc_divv",    div_valid_o,  1);
    check("t7_nc_wbv",     wb_valid_o,   0);
    respond(0, 32'd14);
    check("t7_nc_result",  wb_result_o,  32'd14);
    cyc();
`endif
    issue(DIV_DIVU, 32'd100, 32'd7, 1'b1);
    check("t7_dit_divv",   div_valid_o, 1);
    check("t7_dit_out",    div_dit_o,   1);
    respond(0, 32'd14);
    check("t7_dit_result", wb_result_o, 32'd14);
    cyc();

    // Reset in the middle of an operation
    issue(DIV_DIVU, 32'd8, 32'd2, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t8_busy",       busy_o,       0);
    check("t8_divv",       div_valid_o,  0);
    check("t8_op_a",       div_op_a_o,   0);
    check("t8_result",     wb_result_o,  0);
    check("t8_cycles",     div_cycles_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
